// File: rtl/joy_debounce_autofire.sv
// Joystick conditioning: per-bit debounce of both ports plus optional
// fire-button autofire, idle (all released) until the input stage is ready.
module joy_debounce_autofire #(
    parameter int DEB_CYCLES = 28000,
    parameter int AF_HALF    = 1400000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] joya_in,
    input  logic [7:0] joyb_in,
    input  logic [1:0] autofire_en,
    output logic [7:0] joya_out,
    output logic [7:0] joyb_out,
    output logic       joy_evt
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int AW = $clog2(AF_HALF);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] AF_MAX  = AW'(AF_HALF - 1);

    typedef enum logic [1:0] {
        AF_OFF,
        AF_LOW,
        AF_HIGH
    } af_state_t;

    logic [5:0]    raw    [2];
    logic [5:0]    stab   [2];
    logic [CW-1:0] cnt    [2][6];
    af_state_t     af_st  [2];
    logic [AW-1:0] af_cnt [2];
    logic          af_bit [2];
    logic [7:0]    nxt    [2];
    logic          unused_bits;

    assign raw[0] = joya_in[5:0];
    assign raw[1] = joyb_in[5:0];
    // Bits 7:6 are always reported released, so the raw values are ignored.
    assign unused_bits = ^{joya_in[7:6], joyb_in[7:6]};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            af_bit[p] = (af_st[p] == AF_OFF) ? stab[p][4] : (af_st[p] == AF_HIGH);
            nxt[p]    = {2'b11, stab[p][5], af_bit[p], stab[p][3:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !ready) begin
            for (int p = 0; p < 2; p++) begin
                stab[p]   <= '1;
                af_st[p]  <= AF_OFF;
                af_cnt[p] <= '0;
                for (int i = 0; i < 6; i++) begin
                    cnt[p][i] <= '0;
                end
            end
            joya_out <= 8'hFF;
            joyb_out <= 8'hFF;
            // Dropping ready still announces the return to idle; reset does not.
            joy_evt  <= !rst && ((joya_out != 8'hFF) || (joyb_out != 8'hFF));
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 6; i++) begin
                    if (raw[p][i] == stab[p][i]) begin
                        cnt[p][i] <= '0;
                    end else if (cnt[p][i] == DEB_MAX) begin
                        stab[p][i] <= raw[p][i];
                        cnt[p][i]  <= '0;
                    end else begin
                        cnt[p][i] <= cnt[p][i] + 1'b1;
                    end
                end

                unique case (af_st[p])
                    AF_OFF: begin
                        af_cnt[p] <= '0;
                        if (autofire_en[p] && !stab[p][4]) begin
                            af_st[p] <= AF_LOW;
                        end
                    end
                    AF_LOW, AF_HIGH: begin
                        // Release or disable wins over a pending phase flip.
                        if (stab[p][4] || !autofire_en[p]) begin
                            af_st[p]  <= AF_OFF;
                            af_cnt[p] <= '0;
                        end else if (af_cnt[p] == AF_MAX) begin
                            af_st[p]  <= (af_st[p] == AF_LOW) ? AF_HIGH : AF_LOW;
                            af_cnt[p] <= '0;
                        end else begin
                            af_cnt[p] <= af_cnt[p] + 1'b1;
                        end
                    end
                    default: begin
                        af_st[p]  <= AF_OFF;
                        af_cnt[p] <= '0;
                    end
                endcase
            end

            joya_out <= nxt[0];
            joyb_out <= nxt[1];
            joy_evt  <= (nxt[0] != joya_out) || (nxt[1] != joyb_out);
        end
    end

endmodule

// File: tb/tb_joy_debounce_autofire.sv
// Scoreboard bench for joy_debounce_autofire (DEB_CYCLES=4, AF_HALF=8):
// stimulus queues per-cycle expectations, a monitor compares after each edge.
module tb_joy_debounce_autofire;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] joya_in;
    logic [7:0] joyb_in;
    logic [1:0] autofire_en;
    logic [7:0] joya_out;
    logic [7:0] joyb_out;
    logic       joy_evt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ev;
        string      tag;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] prev   = 16'hFFFF;

    joy_debounce_autofire #(
        .DEB_CYCLES(4),
        .AF_HALF   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .joya_in    (joya_in),
        .joyb_in    (joyb_in),
        .autofire_en(autofire_en),
        .joya_out   (joya_out),
        .joyb_out   (joyb_out),
        .joy_evt    (joy_evt)
    );

    always #5 clk = ~clk;

    // Expected port A word for cycle k after fire is first held with autofire on:
    // released until the debounce settles, then low 9 cycles (pass-through
    // cycle + first LOW phase), then alternating 8 high / 8 low.
    function automatic logic [7:0] af_word(input int k);
        if (k < 4)
            return 8'hFF;
        if (k <= 12)
            return 8'hEF;
        return (((k - 13) / 8) % 2 == 0) ? 8'hFF : 8'hEF;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic rd, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] en,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input string tag);
        exp_t e;
        @(negedge clk);
        rst         = r;
        ready       = rd;
        joya_in     = a;
        joyb_in     = b;
        autofire_en = en;
        e.a   = ea;
        e.b   = eb;
        e.ev  = !r && ({ea, eb} != prev);
        e.tag = tag;
        prev  = {ea, eb};
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (joya_out !== mon_e.a || joyb_out !== mon_e.b || joy_evt !== mon_e.ev) begin
                errors++;
                $display("FAIL %s: got a=%h b=%h evt=%b, want a=%h b=%h evt=%b",
                         mon_e.tag, joya_out, joyb_out, joy_evt,
                         mon_e.a, mon_e.b, mon_e.ev);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        ready       = 1'b0;
        joya_in     = 8'hFF;
        joyb_in     = 8'hFF;
        autofire_en = 2'b00;

        repeat (3) cyc(1, 0, 8'hFF, 8'hFF, 2'b00, 8'hFF, 8'hFF, "reset");
        cyc(1, 1, 8'hFF, 8'hFF, 2'b00, 8'hFF, 8'hFF, "reset_ready");
        repeat (4) cyc(0, 1, 8'hFF, 8'hFF, 2'b00, 8'hFF, 8'hFF, "idle");

        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hFE, 8'hFF, 2'b00, (k >= 4) ? 8'hFE : 8'hFF, 8'hFF, "deb_press");
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hFF, 8'hFF, 2'b00, (k >= 4) ? 8'hFF : 8'hFE, 8'hFF, "deb_release");

        for (int k = 0; k < 3; k++)
            cyc(0, 1, 8'hFE, 8'hFF, 2'b00, 8'hFF, 8'hFF, "glitch");
        for (int k = 0; k < 6; k++)
            cyc(0, 1, 8'hFF, 8'hFF, 2'b00, 8'hFF, 8'hFF, "glitch_after");

        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'h3F, 8'h00, 2'b00, 8'hFF, (k >= 4) ? 8'hC0 : 8'hFF, "force76");
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hFF, 8'hFF, 2'b00, 8'hFF, (k >= 4) ? 8'hFF : 8'hC0, "force76_rel");
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hFE, 8'hFD, 2'b00, (k >= 4) ? 8'hFE : 8'hFF,
                (k >= 4) ? 8'hFD : 8'hFF, "both_press");
        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hFF, 8'hFF, 2'b00, (k >= 4) ? 8'hFF : 8'hFE,
                (k >= 4) ? 8'hFF : 8'hFD, "both_release");

        for (int k = 0; k < 22; k++)
            cyc(0, 1, 8'hEF, 8'hFF, 2'b01, af_word(k), 8'hFF, "af_run");
        for (int k = 22; k < 37; k++)
            cyc(0, 1, 8'hFF, 8'hFF, 2'b01, (k <= 26) ? af_word(k) : 8'hFF, 8'hFF, "af_release");

        for (int k = 0; k < 8; k++)
            cyc(0, 1, 8'hEF, 8'hFF, 2'b01, af_word(k), 8'hFF, "af_pre_drop");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, 8'hEF, 8'hFF, 2'b01, 8'hFF, 8'hFF, "ready_drop");
        for (int k = 0; k < 22; k++)
            cyc(0, 1, 8'hEF, 8'hFF, 2'b01, af_word(k), 8'hFF, "af_recover");
        for (int k = 22; k < 33; k++)
            cyc(0, 1, 8'hEF, 8'hFF, 2'b00, 8'hEF, 8'hFF, "af_disable");

        repeat (2) cyc(1, 0, 8'hFF, 8'hFF, 2'b00, 8'hFF, 8'hFF, "final_reset");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
